regfile_wb_sched: RTL
=====================

Name: regfile_wb_sched

Overview:
- Writeback scheduler and scoreboard in front of the register file's single write port.
- Arbitrates between two writeback requesters, the ALU path and the load/memory path, and drives one registered write per cycle into the register file.
- Tracks in-flight destination registers so decode can stall on RAW hazards and refuse issue on WAW hazards.

Parameters:
- ADDR_W, 5, register address width (32 registers).
- DATA_W, 32, register data width.
- STARVE_MAX, 3, consecutive ALU losses after which ALU is forced to win (fixed-priority mode only).

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous active-high reset.
- rdy_in  input  1  global ready; low freezes the block.
- issue_valid  input  1  decode allocates a destination this cycle.
- issue_addr  input  ADDR_W  destination register being allocated.
- issue_ready  output  1  allocation accepted (combinational).
- rd_en1  input  1  decode read port 1 enable.
- rd_addr1  input  ADDR_W  decode read port 1 address.
- rd_en2  input  1  decode read port 2 enable.
- rd_addr2  input  ADDR_W  decode read port 2 address.
- hazard_stall  output  1  RAW hazard on either enabled read (combinational).
- alu_valid  input  1  ALU writeback request.
- alu_addr  input  ADDR_W  ALU writeback address.
- alu_data  input  DATA_W  ALU writeback data.
- alu_ready  output  1  ALU handshake completes (combinational).
- mem_valid  input  1  load writeback request.
- mem_addr  input  ADDR_W  load writeback address.
- mem_data  input  DATA_W  load writeback data.
- mem_ready  output  1  load handshake completes (combinational).
- we  output  1  register file write enable (registered).
- w_addr  output  ADDR_W  register file write address (registered).
- w_data  output  DATA_W  register file write data (registered).

Behaviour:
- Reset (rst_in=1 at posedge): pending[31:0]=0; we=0, w_addr=0, w_data=0; starve counter=0; RR pointer=ALU. Reset mid-transfer discards any accepted-but-unwritten write.
- rdy_in=0: all state held, including we/w_addr/w_data; alu_ready=mem_ready=issue_ready=0; hazard_stall=0.
- Handshake:
  - A transfer occurs on the cycle valid&&ready is high.
  - Ready is combinational from the valids and arbitration state only, never from the other requester's ready.
  - A requester must hold valid, addr and data stable until its handshake completes.
- Arbitration (fixed mode):
  - If only one requester is valid, it is granted.
  - If both are valid, mem wins unless starve==STARVE_MAX, in which case ALU wins.
  - starve increments each cycle alu_valid is high and ALU is not granted, saturating at STARVE_MAX.
  - starve clears to 0 on any ALU grant or any cycle with alu_valid=0.
- Write output latency:
  - The handshake at cycle N gives we=1, w_addr, w_data at cycle N+1, registered for exactly one cycle.
  - we=0 on cycles following no handshake.
  - A handshake with addr 0 completes normally but produces we=0.
- Scoreboard:
  - pending[a] is set on issue_valid&&issue_ready with a!=0.
  - pending[a] is cleared on the cycle we=1 and w_addr=a.
  - If set and clear hit the same address in the same cycle, set wins.
  - pending[0] is constantly 0.
- issue_ready = !pending[issue_addr] || (we && w_addr==issue_addr). Issue to addr 0 is always ready and has no effect.
- hazard_stall for port k = rd_enk && rd_addrk!=0 && pending[rd_addrk] && !(we && w_addr==rd_addrk). The exception exists because the register file bypasses a same-cycle write to the reader.
- Writeback to a non-pending address is still written. The scoreboard is unchanged apart from the normal clear.
- Throughput: one write per cycle sustained. The losing requester waits with no bubble inserted.

Optional Feature:
- Macro: WB_ROUND_ROBIN_EN.
- Defined:
  - When both requesters are valid, priority alternates.
  - The RR pointer flips to the non-granted requester after every conflicted grant; it is unchanged when only one requester is valid.
  - The starve counter and STARVE_MAX are unused.
- Undefined: fixed mem priority with the starvation guard, as above.

Test Plan:
- Reset, then issue x5 → pending[5]=1. alu_valid with addr 5, data 0xDEADBEEF → alu_ready=1; next cycle we=1, w_addr=5, w_data=0xDEADBEEF, and pending[5] clears after that edge.
- Read of x5 while pending[5]=1 and we=0 → hazard_stall=1. Same read on the cycle we=1, w_addr=5 → hazard_stall=0.
- alu_valid and mem_valid held high continuously, fixed mode, STARVE_MAX=3 → grant sequence mem, mem, mem, alu, mem, mem, mem, alu. With WB_ROUND_ROBIN_EN → alu, mem, alu, mem.
- Issue x7 while pending[7]=1 → issue_ready=0. Issue x7 on the cycle we writes x7 → issue_ready=1 and pending[7] remains 1.
- mem_valid with addr 0, data 0x1234 → mem_ready=1; next cycle we=0; hazard_stall=0 for reads of x0; issue to x0 always ready.
- rdy_in=0 for 3 cycles mid-conflict → readys=0, we and pending frozen. Assert rst_in during an accepted write → next cycle we=0 and all pending bits clear.

Source files
------------

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler and scoreboard for the register file's single write port.
// Arbitrates ALU and load writebacks into one registered write per cycle and tracks
// in-flight destinations for RAW stall / WAW issue refusal.
// Optional feature: define WB_ROUND_ROBIN_EN for alternating priority on conflicts;
// otherwise mem has fixed priority with an ALU starvation guard.
module regfile_wb_sched #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_ready,
  input  logic              rd_en1,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic              rd_en2,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              hazard_stall,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              we,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data
);

  localparam int unsigned NumRegs = 1 << ADDR_W;

  logic [NumRegs-1:0] pending_q, pending_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  w_addr_q, w_addr_d;
  logic [DATA_W-1:0]  w_data_q, w_data_d;
  logic               alu_win;
  logic               alu_fire, mem_fire;
  logic               haz1, haz2;

`ifdef WB_ROUND_ROBIN_EN
  // 1: ALU has priority on the next conflict, 0: mem has priority.
  logic rr_q, rr_d;
`else
  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
  logic [StarveW-1:0] starve_q, starve_d;
`endif

  assign we     = we_q;
  assign w_addr = w_addr_q;
  assign w_data = w_data_q;

  // Arbitration, handshakes and decode-side hazard/issue checks.
  always_comb begin
`ifdef WB_ROUND_ROBIN_EN
    alu_win = rr_q;
`else
    alu_win = (starve_q == StarveW'(STARVE_MAX));
`endif
    // Readys depend only on valids and arbitration state, never on each other.
    alu_ready = rdy_in && alu_valid && (!mem_valid || alu_win);
    mem_ready = rdy_in && mem_valid && (!alu_valid || !alu_win);
    alu_fire  = alu_valid && alu_ready;
    mem_fire  = mem_valid && mem_ready;

    // The register file bypasses a same-cycle write, so that write hides the hazard.
    haz1 = rd_en1 && (rd_addr1 != '0) && pending_q[rd_addr1] && !(we_q && w_addr_q == rd_addr1);
    haz2 = rd_en2 && (rd_addr2 != '0) && pending_q[rd_addr2] && !(we_q && w_addr_q == rd_addr2);
    hazard_stall = rdy_in && (haz1 || haz2);

    issue_ready = rdy_in && (!pending_q[issue_addr] || (we_q && w_addr_q == issue_addr));
  end

  // Next-state: write pipeline, scoreboard and arbitration history; all held when !rdy_in.
  always_comb begin
    we_d      = we_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    pending_d = pending_q;
`ifdef WB_ROUND_ROBIN_EN
    rr_d      = rr_q;
`else
    starve_d  = starve_q;
`endif
    if (rdy_in) begin
      we_d = 1'b0;
      if (alu_fire) begin
        we_d     = (alu_addr != '0);
        w_addr_d = alu_addr;
        w_data_d = alu_data;
      end else if (mem_fire) begin
        we_d     = (mem_addr != '0);
        w_addr_d = mem_addr;
        w_data_d = mem_data;
      end

      // Clear first so a same-cycle set to the same address wins.
      if (we_q) pending_d[w_addr_q] = 1'b0;
      if (issue_valid && issue_ready) pending_d[issue_addr] = 1'b1;
      pending_d[0] = 1'b0;

`ifdef WB_ROUND_ROBIN_EN
      if (alu_valid && mem_valid) rr_d = !alu_fire;
`else
      if (alu_valid && !alu_fire) begin
        starve_d = (starve_q == StarveW'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;
      end else begin
        starve_d = '0;
      end
`endif
    end
  end

  // State registers with synchronous reset; reset drops any accepted-but-unwritten write.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pending_q <= '0;
      we_q      <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
`ifdef WB_ROUND_ROBIN_EN
      rr_q      <= 1'b1;
`else
      starve_q  <= '0;
`endif
    end else begin
      pending_q <= pending_d;
      we_q      <= we_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
`ifdef WB_ROUND_ROBIN_EN
      rr_q      <= rr_d;
`else
      starve_q  <= starve_d;
`endif
    end
  end

endmodule
